// File: rtl/seg_scan_ctrl.sv
// Scan controller for the "show" path: snapshots four 0..99 channel values, converts
// them to two seven-segment digits each, and multiplexes the 8 digits onto an active-low display.
module seg_scan_ctrl #(
    parameter int unsigned CLK_DIV  = 50000,
    parameter bit          LZ_BLANK = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [27:0] ch_data,
    input  logic [3:0]  blank,
    input  logic        update,
    output logic [7:0]  an,
    output logic [7:0]  seg,
    output logic        busy,
    output logic        frame_done
);

    localparam int unsigned      CNT_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [7:0]       CODE_DARK = 8'hFF;
    localparam logic [7:0]       CODE_DASH = 8'hBF;

    typedef enum logic [1:0] {
        ST_CAPTURE,
        ST_CONV,
        ST_SCAN
    } state_t;

    // Shift-add-3 conversion; the hundreds nibble is only used to flag out-of-range values.
    function automatic logic [11:0] bin2bcd(input logic [6:0] bin);
        logic [11:0] bcd;
        logic [6:0]  b;
        bcd = '0;
        b   = bin;
        for (int unsigned i = 0; i < 7; i++) begin
            if (bcd[3:0] >= 4'd5) bcd[3:0] = bcd[3:0] + 4'd3;
            if (bcd[7:4] >= 4'd5) bcd[7:4] = bcd[7:4] + 4'd3;
            bcd = {bcd[10:0], b[6]};
            b   = {b[5:0], 1'b0};
        end
        return bcd;
    endfunction

    function automatic logic [7:0] seg_code(input logic [3:0] d);
        logic [7:0] c;
        case (d)
            4'd0:    c = 8'hC0;
            4'd1:    c = 8'hF9;
            4'd2:    c = 8'hA4;
            4'd3:    c = 8'hB0;
            4'd4:    c = 8'h99;
            4'd5:    c = 8'h92;
            4'd6:    c = 8'h82;
            4'd7:    c = 8'hF8;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h90;
            default: c = CODE_DARK;
        endcase
        return c;
    endfunction

    state_t           state_q, state_d;
    logic             pending_q, pending_d;
    logic [27:0]      snap_data_q, snap_data_d;
    logic [3:0]       snap_blank_q, snap_blank_d;
    logic [1:0]       conv_ch_q, conv_ch_d;
    logic [2:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       digit_q [8];
    logic [7:0]       digit_d [8];
    logic [7:0]       an_q, an_d;
    logic [7:0]       seg_q, seg_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;

    logic [6:0]       conv_val;
    logic             conv_blank;
    logic [11:0]      conv_bcd;
    logic [7:0]       tens_code;
    logic [7:0]       ones_code;

    // Shared converter: works on whichever snapshot channel the CONV step points at.
    always_comb begin
        conv_val   = snap_data_q[32'(conv_ch_q) * 7 +: 7];
        conv_blank = snap_blank_q[conv_ch_q];
        conv_bcd   = bin2bcd(conv_val);
        tens_code  = seg_code(conv_bcd[7:4]);
        ones_code  = seg_code(conv_bcd[3:0]);
        if (conv_blank) begin
            tens_code = CODE_DARK;
            ones_code = CODE_DARK;
        end else if (conv_bcd[11:8] != 4'd0) begin
            tens_code = CODE_DASH;
            ones_code = CODE_DASH;
        end else if (conv_bcd[7:4] == 4'd0 && LZ_BLANK) begin
            tens_code = CODE_DARK;
        end
    end

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q | update;
        snap_data_d  = snap_data_q;
        snap_blank_d = snap_blank_q;
        conv_ch_d    = conv_ch_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        digit_d      = digit_q;

        case (state_q)
            ST_CAPTURE: begin
                snap_data_d  = ch_data;
                snap_blank_d = blank;
                pending_d    = update;
                conv_ch_d    = 2'd0;
                state_d      = ST_CONV;
            end
            ST_CONV: begin
                digit_d[{conv_ch_q, 1'b0}] = ones_code;
                digit_d[{conv_ch_q, 1'b1}] = tens_code;
                conv_ch_d = conv_ch_q + 2'd1;
                if (conv_ch_q == 2'd3) begin
                    state_d = ST_SCAN;
                    idx_d   = 3'd0;
                    cnt_d   = '0;
                end
            end
            ST_SCAN: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    idx_d = idx_q + 3'd1;
                    // pending_q, not pending_d: an update on the frame's last cycle waits a frame.
                    if (idx_q == 3'd7 && pending_q) begin
                        state_d = ST_CAPTURE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_CAPTURE;
        endcase

        // Outputs are registered from next-state values so a slot is visible on its first cycle.
        an_d         = 8'hFF;
        seg_d        = 8'hFF;
        busy_d       = (state_d != ST_SCAN);
        frame_done_d = (state_d == ST_SCAN) && (idx_d == 3'd7) && (cnt_d == CNT_LAST);
        if (state_d == ST_SCAN) begin
            an_d  = ~(8'h01 << idx_d);
            seg_d = digit_d[idx_d];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_CAPTURE;
            pending_q    <= 1'b0;
            snap_data_q  <= '0;
            snap_blank_q <= '0;
            conv_ch_q    <= 2'd0;
            idx_q        <= 3'd0;
            cnt_q        <= '0;
            for (int unsigned i = 0; i < 8; i++) begin
                digit_q[i] <= CODE_DARK;
            end
            an_q         <= '1;
            seg_q        <= '1;
            busy_q       <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            snap_data_q  <= snap_data_d;
            snap_blank_q <= snap_blank_d;
            conv_ch_q    <= conv_ch_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            digit_q      <= digit_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a frame-level timeline model predicts every digit slot
// and frame_done pulse; a negedge monitor pops and compares as the display presents them.
module tb_seg_scan_ctrl;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [27:0] ch_data = '0;
    logic [3:0]  blank = '0;
    logic        update = 1'b0;
    logic [7:0]  an, seg, an2, seg2;
    logic        busy, frame_done, busy2, frame_done2;

    seg_scan_ctrl #(.CLK_DIV(D), .LZ_BLANK(1'b1)) u_dut (
        .clk(clk), .rst(rst), .ch_data(ch_data), .blank(blank), .update(update),
        .an(an), .seg(seg), .busy(busy), .frame_done(frame_done)
    );

    seg_scan_ctrl #(.CLK_DIV(D), .LZ_BLANK(1'b0)) u_dut_nolz (
        .clk(clk), .rst(rst), .ch_data(ch_data), .blank(blank), .update(update),
        .an(an2), .seg(seg2), .busy(busy2), .frame_done(frame_done2)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         start;
        logic [7:0] an;
        logic [7:0] seg;
        logic [7:0] seg_nolz;
    } slot_t;

    slot_t sb_q[$];
    int    fd_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int edge_n   = 0;
    bit mon_en   = 1'b0;

    logic [7:0] seg_tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, exp, edge_n);
    endtask

    function automatic logic [7:0] exp_code(input int v, input bit b, input bit is_tens, input bit lz);
        if (b) return 8'hFF;
        if (v > 99) return 8'hBF;
        if (is_tens) begin
            if (v / 10 == 0 && lz) return 8'hFF;
            return seg_tbl[v / 10];
        end
        return seg_tbl[v % 10];
    endfunction

    // Timeline model: capture edge c -> slot i starts after edge c+4+i*D; the frame ends at
    // edge c+4+8*D and re-captures only if an update was sampled at edges [c, end-1].
    int          cap_edge  = -1;
    int          frame_end = -1;
    int          frame_start;
    bit          upd;
    logic [27:0] snap_d;
    logic [3:0]  snap_b;

    task automatic push_frame();
        for (int i = 0; i < 8; i++) begin
            slot_t s;
            int    v;
            bit    b;
            v = int'(snap_d[7 * (i / 2) +: 7]);
            b = snap_b[i / 2];
            s.start    = frame_start + i * D;
            s.an       = ~(8'h01 << i);
            s.seg      = exp_code(v, b, (i % 2) == 1, 1'b1);
            s.seg_nolz = exp_code(v, b, (i % 2) == 1, 1'b0);
            sb_q.push_back(s);
        end
        fd_q.push_back(frame_start + 8 * D - 1);
    endtask

    task automatic model_edge();
        if (rst) begin
            sb_q.delete();
            fd_q.delete();
            cap_edge  = edge_n + 1;
            frame_end = -1;
            upd       = 1'b0;
        end else if (edge_n == cap_edge) begin
            snap_d      = ch_data;
            snap_b      = blank;
            upd         = update;
            frame_start = edge_n + 4;
            frame_end   = frame_start + 8 * D;
            push_frame();
        end else if (edge_n == frame_end) begin
            if (upd) begin
                cap_edge  = edge_n + 1;
                frame_end = -1;
            end else begin
                frame_start = edge_n;
                frame_end   = edge_n + 8 * D;
                push_frame();
                upd = update;
            end
        end else begin
            upd = upd | update;
        end
    endtask

    task automatic step();
        @(posedge clk);
        edge_n++;
        model_edge();
        #1;
        update = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_an(input logic [7:0] target, input string name);
        int n = 0;
        while (an !== target && n < 300) begin
            step();
            n++;
        end
        check(name, 32'(n < 300), 32'd1);
    endtask

    task automatic wait_busy(input string name);
        int n = 0;
        while (busy !== 1'b1 && n < 300) begin
            step();
            n++;
        end
        check(name, 32'(n < 300), 32'd1);
    endtask

    // Monitor: one expected slot per new lit anode pattern, one expected edge per frame_done.
    logic [7:0] prev_an  = 8'hFF;
    logic [7:0] slot_seg = 8'hFF;
    slot_t      mon_s;

    always @(negedge clk) begin
        if (mon_en) begin
            check("twin_an", an2, an);
            check("twin_ctrl", {busy2, frame_done2}, {busy, frame_done});
            if (an != 8'hFF && an != prev_an) begin
                if (sb_q.size() == 0) begin
                    check("slot_unexpected", an, 8'hFF);
                    slot_seg = 8'hFF;
                end else begin
                    mon_s = sb_q.pop_front();
                    check("slot_start", edge_n, mon_s.start);
                    check("slot_an", an, mon_s.an);
                    check("slot_seg", seg, mon_s.seg);
                    check("slot_seg_nolz", seg2, mon_s.seg_nolz);
                    slot_seg = mon_s.seg;
                end
            end
            if (an == 8'hFF) check("dark_seg_busy", {seg, busy}, {8'hFF, 1'b1});
            else             check("lit_seg_busy", {seg, busy}, {slot_seg, 1'b0});
            if (frame_done) begin
                if (fd_q.size() == 0) check("fd_unexpected", 32'd1, 32'd0);
                else                  check("frame_done_edge", edge_n, fd_q.pop_front());
            end
            prev_an = an;
        end
    end

    logic [27:0] conv_set;

    initial begin
        conv_set = {7'd100, 7'd99, 7'd7, 7'd42};

        rst = 1'b1;
        step();
        mon_en = 1'b1;
        run(2);
        check("reset_state", {an, seg, busy, frame_done}, {8'hFF, 8'hFF, 1'b1, 1'b0});
        rst = 1'b0;
        run(80);

        ch_data = conv_set;
        update  = 1'b1;
        run(100);

        ch_data[13:7] = 7'd55;
        blank         = 4'b0010;
        update        = 1'b1;
        run(90);

        blank   = 4'b0000;
        ch_data = conv_set;
        update  = 1'b1;
        run(80);
        wait_an(8'hFB, "wait_slot2");
        ch_data[6:0] = 7'd13;
        update       = 1'b1;
        run(5);
        update = 1'b1;
        run(100);

        ch_data[6:0] = 7'd64;
        update       = 1'b1;
        step();
        wait_busy("wait_capture");
        run(3);
        ch_data[6:0] = 7'd88;
        update       = 1'b1;
        run(120);

        wait_an(8'hDF, "wait_slot5");
        step();
        rst = 1'b1;
        step();
        check("rst_mid", {an, seg, busy, frame_done}, {8'hFF, 8'hFF, 1'b1, 1'b0});
        rst = 1'b0;
        run(80);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) update = 1'b1;
            if ($urandom_range(0, 9) == 0) begin
                int k;
                k = int'($urandom_range(0, 3));
                ch_data[7 * k +: 7] = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(100, 127))
                                                                  : 7'($urandom_range(0, 99));
            end
            if ($urandom_range(0, 29) == 0) blank = 4'($urandom_range(0, 15));
            rst = ($urandom_range(0, 699) == 0);
            step();
        end
        rst = 1'b0;
        run(10);

        @(negedge clk);
        #1;
        check("drain_slots", 32'(sb_q.size() == 0 || sb_q[0].start > edge_n), 32'd1);
        check("drain_frame_done", 32'(fd_q.size() == 0 || fd_q[0] > edge_n), 32'd1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Display scan controller for the "show" path. It snapshots four 7-bit binary channel values and converts each to two BCD digits through one shared binary-to-BCD converter, one channel per cycle. It then time-multiplexes the resulting 8 digits onto a common-anode, active-low seven-segment display. It sits between the value sources (counters, timers) and the board display pins.

Parameters:
CLK_DIV, 50000, clock cycles per digit slot; legal range 2..2^20.
LZ_BLANK, 1, 1 = blank the tens digit when it is 0; 0 = show "0".

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
ch_data  input  28  four channels; ch k = ch_data[7k+6:7k]; legal values 0..99
blank  input  4  blank[k]=1 -> both digits of ch k dark (sampled at capture)
update  input  1  one-cycle request to re-snapshot ch_data/blank
an  output  8  anode enables, active-low, one-hot in SCAN; an[i] selects digit i
seg  output  8  seg[6:0]=g..a active-low, seg[7]=dp, always 1
busy  output  1  high in CAPTURE and CONV
frame_done  output  1  one-cycle pulse on the last cycle of the digit-7 slot

Behaviour:
- One clock; reset is synchronous and active-high. Ports are clk and rst.
- Reset: state=CAPTURE, pending=0, digit index=0, slot counter=0, all digit registers = blank code. Outputs: an=8'hFF, seg=8'hFF, busy=1, frame_done=0.
- States:
  - CAPTURE: 1 cycle. Latch ch_data and blank into snapshot registers. Clear pending. Go to CONV.
  - CONV: 4 cycles. Cycle j feeds snapshot ch j to the shared converter (tens, ones). The result is written into digit registers 2j (ones) and 2j+1 (tens). After j=3, go to SCAN with index=0 and counter=0.
  - SCAN: each slot lasts exactly CLK_DIV cycles.
    - On the last cycle of a slot, index increments mod 8 and the counter clears.
    - On the last cycle of the index-7 slot, frame_done=1. If pending=1, go to CAPTURE; otherwise continue at index 0.
- Outputs are registered. On the first SCAN cycle of slot i: an=~(1<<i), seg=code(digit i). In CAPTURE and CONV, an=8'hFF and seg=8'hFF. The blank gap between frames is therefore 5 cycles.
- Digit code rules, evaluated at CONV write time, first match wins:
  - blank[k]=1 -> 8'hFF on both digits.
  - Value >99 -> dash 8'hBF on both digits.
  - Tens digit =0 and LZ_BLANK=1 -> tens digit 8'hFF.
  - Otherwise, BCD code: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90.
- update handling:
  - Sampled in every state; sets pending.
  - Never interrupts a frame. It is serviced at the next frame end.
  - An update arriving during CAPTURE or CONV sets pending, so one more refresh follows the next frame.
  - Multiple updates before service collapse into one.
- ch_data changes outside CAPTURE have no effect on the display.
- frame_done and update in the same cycle: the update is serviced at the following frame end, not the current one.
- rst mid-SCAN or mid-CONV: the reset values above apply on the next cycle; the partial frame is discarded.
- Slot counter width is clog2(CLK_DIV). The index is 3 bits and wraps 7->0.

Test Plan:
- Reset/startup, CLK_DIV=4, ch_data all 0, blank=0, LZ_BLANK=1: after rst drops, an=FF for 5 cycles. Then the an sequence is FE,FD,...,7F, 4 cycles each. Even digits show seg=C0, odd digits show FF. frame_done pulses once per 32 cycles.
- Conversion, ch0=42, ch1=7, ch2=99, ch3=100: digit0..7 seg = A4,99, F8,FF, 90,90, BF,BF. With LZ_BLANK=0, digit3 = C0.
- Blank, blank=4'b0010 with ch1=55: digits 2 and 3 show FF while their anodes are still enabled; other channels are unaffected.
- Deferred update: change ch0 from 42 to 13 and pulse update during the index-2 slot. The current frame still shows 42. After frame_done there is a 5-cycle dark gap (busy=1), then digit0=B0 and digit1=F9. Two updates in one frame produce only one gap.
- Update in CONV: pulse update during CONV cycle 2. The next frame shows the capture-time data, and exactly one further refresh gap follows that frame.
- Reset mid-operation: assert rst during the index-5 slot. The next cycle has an=FF, seg=FF, busy=1, frame_done=0, and the startup sequence repeats exactly.
